// File: rtl/dec_to_bcd_keyenc.sv
// dec_to_bcd_keyenc: synchronizes and debounces 10 decimal key lines, priority-encodes
// the accepted key to BCD and offers it on a valid/ready handshake.
module dec_to_bcd_keyenc #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key,
    output logic [3:0] bcd_out,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       multi_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t           state;
    logic [9:0]       key_m, key_s;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand, enc;
    logic             any, multi;

    always_comb begin
        enc = '0;
        for (int i = 0; i < 10; i++) enc = key_s[i] ? 4'(i) : enc;
    end

    assign any   = |key_s;
    assign multi = |(key_s & (key_s - 10'd1));
    assign busy  = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m     <= '0;
            key_s     <= '0;
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
            case (state)
                IDLE: if (any) begin
                    cand  <= enc;
                    cnt   <= '0;
                    state <= DEBOUNCE;
                end
                DEBOUNCE: if (!any) begin
                    state <= IDLE;
                end else if (enc != cand) begin
                    cand <= enc;
                    cnt  <= '0;
                end else if (cnt == CNT_MAX) begin
                    bcd_out   <= cand;
                    multi_err <= multi;
                    bcd_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HOLD: if (bcd_ready) begin
                    bcd_valid <= 1'b0;
                    cnt       <= '0;
                    state     <= RELEASE;
                end
                RELEASE: if (any) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/dec_to_bcd_keyenc.md
Name: dec_to_bcd_keyenc

Overview:
Sequential decimal-to-BCD encoder. It takes 10 one-hot-style decimal key lines (0-9) from switches or a keypad and synchronizes and debounces them. It then priority-encodes the result to a 4-bit BCD code and presents that code on a valid/ready handshake. It is the source side of the BCD-to-decimal decode path: its bcd_out feeds the existing decoder or display logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or a release; legal range >= 1.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
key  input  10  raw decimal key lines; key[i]=1 means digit i is pressed. Asynchronous to clk.
bcd_out  output  4  encoded BCD digit, 0-9.
bcd_valid  output  1  bcd_out holds a new accepted digit.
bcd_ready  input  1  consumer accepts the digit.
multi_err  output  1  more than one key was set when the digit was accepted; qualified by bcd_valid.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Synchronizer: 2-flop synchronizer on all 10 bits (key_s). The FSM only ever looks at key_s.
- Priority encode: enc = index of the highest set bit of key_s; any = OR of key_s; multi = more than one bit of key_s set.
- Key 0 pressed gives enc=0 with any=1, which is distinct from no key.

FSM states: IDLE, DEBOUNCE, HOLD, RELEASE.
- IDLE:
  - any=1: latch cand<=enc, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - any=0: go to IDLE.
  - enc!=cand: cand<=enc, cnt<=0, stay.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1: bcd_out<=cand, multi_err<=multi, bcd_valid<=1, go to HOLD.
  - Otherwise: cnt<=cnt+1.
- HOLD:
  - bcd_valid stays 1; bcd_out and multi_err stay frozen.
  - On a cycle with bcd_valid&&bcd_ready: bcd_valid<=0, cnt<=0, go to RELEASE.
  - Key changes are ignored while in HOLD.
- RELEASE:
  - any=1: cnt<=0.
  - any=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise: cnt<=cnt+1.
  - A held key never produces a second digit.

Output rules:
- bcd_ready is ignored outside HOLD.
- bcd_out retains the last accepted digit after the handshake; it changes only on entry to HOLD.
- busy = (state!=IDLE), combinational from the state register.

Latency:
- Key stable from sampling edge E0 gives key_s at E1 and the DEBOUNCE entry at E2.
- bcd_valid goes high after edge E(2+DEBOUNCE_CYCLES). With the default that is 6 edges.
- bcd_valid falls on the edge that completes the handshake.

Reset (rst_n low, any time, including mid-debounce or mid-HOLD):
- Immediately, asynchronously clears the sync flops, state=IDLE, cnt=0, cand=0.
- Output reset values: bcd_out=0, bcd_valid=0, multi_err=0, busy=0.
- After rst_n rises, a key already held is treated as a new press. It passes through the full synchronizer plus debounce latency.

Simultaneous events:
- Handshake in the same cycle that keys change: the handshake wins and the FSM goes to RELEASE.
- Counter: saturates by construction, since it never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
1. DEBOUNCE_CYCLES=4, bcd_ready=1, key=10'b0010000000 (digit 7) held -> bcd_valid high exactly 6 edges after first sample, for 1 cycle, with bcd_out=4'd7 and multi_err=0. It does not reassert while the key is held. Release for 4+ cycles -> busy=0.
2. key[0] alone -> bcd_out=4'd0, bcd_valid=1. Then key=10'b0100001000 (digits 3 and 8) after release -> bcd_out=4'd8, multi_err=1.
3. Bounce: key[5] toggles every 2 cycles for 20 cycles, then holds -> no bcd_valid during toggling. A single bcd_valid with bcd_out=4'd5 arrives 6 edges after the final stable edge.
4. Backpressure: digit 9 accepted, bcd_ready=0 for 10 cycles while key changes to digit 2 -> bcd_valid stays 1 and bcd_out stays 4'd9. Raising bcd_ready for 1 cycle -> bcd_valid drops next edge, and digit 2 is not emitted until a release plus a new press.
5. Candidate switch: digit 4 held 2 cycles, then digit 6 held -> bcd_out=4'd6, with valid timed from the switch (restart of cnt).
6. Reset: assert rst_n=0 mid-DEBOUNCE and again mid-HOLD -> bcd_out=0, bcd_valid=0, multi_err=0, busy=0 without waiting for a clock edge. A key held through reset is re-accepted 6 edges after rst_n rises.
